// File: rtl/cond_decode_issue_pkg.sv
// cond_decode_issue_pkg: shared types and constants for the condition-aware
// decode/issue stage.
//   - cond_e   : ARM condition field encoding (EQ..AL, NV=1111)
//   - OP_*     : major opcode values in instruction[27:26]
//   - CMP_*    : compare-only comand range (TST/TEQ/CMP/CMN), no Rd write
//   - BIT_*    : instruction bit positions for S, L, I and link
//   - FLAG_*   : positions inside the {N,Z,C,V} flag nibble
//   - bundle_t : registered decoded bundle handed to execute
package cond_decode_issue_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
    MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
    HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
    GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
  } cond_e;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMP_LO = 4'b1000;
  localparam logic [3:0] CMP_HI = 4'b1011;

  localparam int BIT_S    = 20;
  localparam int BIT_L    = 20;
  localparam int BIT_I    = 25;
  localparam int BIT_LINK = 24;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic [1:0]  op;
    logic [3:0]  comand;
    logic [23:0] imm24;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] imm12;
    logic        cond_pass;
    logic        jmp;
    logic        regjmp;
    logic        flag_en;
    logic        dwr_en;
    logic        dmem_st;
    logic        dmem_en;
    logic        illegal;
  } bundle_t;

  // Compare-only data-processing ops update flags but never write Rd.
  function automatic logic is_cmp(input logic [3:0] cmd);
    return (cmd >= CMP_LO) && (cmd <= CMP_HI);
  endfunction

endpackage

// File: rtl/cond_decode_issue_cond_check.sv
// cond_check: combinational condition-code evaluator.
//   cond_i    : instruction[31:28]
//   nzcv_i    : effective flags {N,Z,C,V}
//   pass_o    : condition holds (0 for NV)
//   illegal_o : cond field is the reserved NV encoding
module cond_check
  import cond_decode_issue_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] nzcv_i,
  output logic       pass_o,
  output logic       illegal_o
);

  logic n, z, c, v;
  assign n = nzcv_i[FLAG_N];
  assign z = nzcv_i[FLAG_Z];
  assign c = nzcv_i[FLAG_C];
  assign v = nzcv_i[FLAG_V];

  assign illegal_o = (cond_i == NV);

  always_comb begin
    pass_o = 1'b0;
    case (cond_e'(cond_i))
      EQ: pass_o = z;
      NE: pass_o = ~z;
      CS: pass_o = c;
      CC: pass_o = ~c;
      MI: pass_o = n;
      PL: pass_o = ~n;
      VS: pass_o = v;
      VC: pass_o = ~v;
      HI: pass_o = c & ~z;
      LS: pass_o = ~c | z;
      GE: pass_o = (n == v);
      LT: pass_o = (n != v);
      GT: pass_o = ~z & (n == v);
      LE: pass_o = z | (n != v);
      AL: pass_o = 1'b1;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_decode_issue.sv
// cond_decode_issue: registered, condition-aware ARM-subset decode/issue stage.
// Accepts one instruction per cycle over valid/ready, evaluates its condition
// against the NZCV register (bypassed from execute's same-cycle flag write),
// and registers a decoded bundle for execute one cycle later.
// Ports:
//   clk, rst_n                  : clock, async active-low reset
//   in_valid/in_ready           : fetch handshake; instruction is the payload
//   flag_wr_valid/flag_wr_data  : execute flag write, retires one pending setter
//   out_valid/out_ready         : execute handshake for the decoded bundle
//   op..memoryimm               : raw instruction fields
//   cond_pass..illegal          : qualified decode enables
//   pend_err                    : sticky, flag write seen with nothing pending
module cond_decode_issue
  import cond_decode_issue_pkg::*;
#(
  parameter int         PEND_W         = 2,
  parameter bit         STALL_ON_FLAGS = 1'b1,
  parameter logic [3:0] PC_REG         = 4'd15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instruction,
  input  logic        flag_wr_valid,
  input  logic [3:0]  flag_wr_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  op,
  output logic [3:0]  comand,
  output logic [23:0] immadiateInst,
  output logic [3:0]  baseAddr,
  output logic [3:0]  dataRegister,
  output logic [11:0] memoryimm,
  output logic        cond_pass,
  output logic        jmpEnable,
  output logic        regjmpEnable,
  output logic        flagEnable,
  output logic        datawriteEnable,
  output logic        datamemory,
  output logic        datamemoryEnable,
  output logic        illegal,
  output logic        pend_err
);

  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [3:0]        flags_q, eff;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              err_q;
  logic              out_valid_q;
  bundle_t           bundle_q, bundle_d;
  logic              cc_pass, cc_ill, qual, stall, accept, inc, dec;
  logic [1:0]        op_f;
  logic [3:0]        cmd_f;

  // The I bit selects operand form, which execute re-reads from immadiateInst.
  logic unused_i_bit;
  assign unused_i_bit = instruction[BIT_I];

  // Same-cycle bypass so a resolving flag write can release a waiting branch.
  assign eff = flag_wr_valid ? flag_wr_data : flags_q;

  cond_check u_cond_check (
    .cond_i    (instruction[31:28]),
    .nzcv_i    (eff),
    .pass_o    (cc_pass),
    .illegal_o (cc_ill)
  );

  assign op_f  = instruction[27:26];
  assign cmd_f = instruction[24:21];

  always_comb begin
    bundle_d           = '0;
    bundle_d.op        = op_f;
    bundle_d.comand    = cmd_f;
    bundle_d.imm24     = instruction[23:0];
    bundle_d.rn        = instruction[19:16];
    bundle_d.rd        = instruction[15:12];
    bundle_d.imm12     = instruction[11:0];
    bundle_d.cond_pass = cc_pass;
    bundle_d.illegal   = cc_ill | (op_f == 2'b11);
    if (qual) begin
      case (op_f)
        OP_DP: begin
          bundle_d.flag_en = instruction[BIT_S];
          bundle_d.dwr_en  = ~is_cmp(cmd_f);
          bundle_d.regjmp  = ~is_cmp(cmd_f) & (instruction[15:12] == PC_REG);
        end
        OP_MEM: begin
          bundle_d.dmem_en = 1'b1;
          bundle_d.dmem_st = ~instruction[BIT_L];
          bundle_d.dwr_en  = instruction[BIT_L];
        end
        OP_BR: begin
          bundle_d.jmp    = 1'b1;
          bundle_d.dwr_en = instruction[BIT_LINK];
        end
        default: ;
      endcase
    end
  end

  assign qual = cc_pass & ~(cc_ill | (op_f == 2'b11));

  // Conditional instructions wait for in-flight flag setters; a write of the
  // last pending setter this cycle is already visible through the bypass.
  // The counter-full stall only matters without a write, when eff==flags_q.
  always_comb begin
    stall = 1'b0;
    if (STALL_ON_FLAGS && (instruction[31:28] != AL) && (pend_q != '0) &&
        !((pend_q == PEND_ONE) && flag_wr_valid))
      stall = 1'b1;
    if (bundle_d.flag_en && (pend_q == PEND_MAX) && !flag_wr_valid)
      stall = 1'b1;
  end

  assign in_ready = (~out_valid_q | out_ready) & ~stall;
  assign accept   = in_valid & in_ready;

  assign inc = accept & bundle_d.flag_en;
  assign dec = flag_wr_valid & (pend_q != '0);

  always_comb begin
    pend_d = pend_q;
    if (inc && !dec)      pend_d = pend_q + PEND_ONE;
    else if (!inc && dec) pend_d = pend_q - PEND_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q     <= '0;
      pend_q      <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
    end else begin
      if (flag_wr_valid) flags_q <= flag_wr_data;
      pend_q <= pend_d;
      if (flag_wr_valid && (pend_q == '0)) err_q <= 1'b1;
      out_valid_q <= accept | (out_valid_q & ~out_ready);
      if (accept) bundle_q <= bundle_d;
    end
  end

  assign out_valid        = out_valid_q;
  assign op               = bundle_q.op;
  assign comand           = bundle_q.comand;
  assign immadiateInst    = bundle_q.imm24;
  assign baseAddr         = bundle_q.rn;
  assign dataRegister     = bundle_q.rd;
  assign memoryimm        = bundle_q.imm12;
  assign cond_pass        = bundle_q.cond_pass;
  assign jmpEnable        = bundle_q.jmp;
  assign regjmpEnable     = bundle_q.regjmp;
  assign flagEnable       = bundle_q.flag_en;
  assign datawriteEnable  = bundle_q.dwr_en;
  assign datamemory       = bundle_q.dmem_st;
  assign datamemoryEnable = bundle_q.dmem_en;
  assign illegal          = bundle_q.illegal;
  assign pend_err         = err_q;

endmodule
